// File: rtl/pgm_fetch_unit_if.sv
// Fetch-unit bus: program-memory read port, decode valid/ready handshake and run control.
interface pgm_fetch_unit_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned IW = 15
);
    logic          start;
    logic [AW-1:0] adp_bus;
    logic          rd;
    logic [IW-1:0] pgm_line;
    logic          jmp_flag;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          halted;

    modport master (
        input  start, pgm_line, jmp_flag, instr_ready,
        output adp_bus, rd, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, pgm_line, jmp_flag, instr_ready,
        input  adp_bus, rd, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/pgm_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads the 32x15 program memory and
// resolves JMP locally, forwarding all other lines over a valid/ready handshake.
module pgm_fetch_unit #(
    parameter int unsigned   AW       = 5,
    parameter int unsigned   IW       = 15,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic               clk_pgm,
    input  logic               rst_n,
    pgm_fetch_unit_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] adp_q;
    logic          rd_q;
    logic [IW-1:0] instr_q;
    logic [AW-1:0] instr_pc_q;
    logic          load_instr;

    logic [3:0]    opcode;
    logic [2:0]    reg_field;
    logic [AW-1:0] addr_field;

    assign opcode     = bus.pgm_line[14:11];
    assign reg_field  = bus.pgm_line[10:8];
    assign addr_field = AW'(bus.pgm_line[7:3]);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_instr = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    pc_d    = RESET_PC;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (opcode != 4'b0000) begin
                    load_instr = 1'b1;
                    pc_d       = pc_q + AW'(1);
                    state_d    = S_HOLD;
                end else if (reg_field == 3'b000 && addr_field == pc_q) begin
                    state_d = S_HALT;
                end else if (reg_field == 3'b000 || bus.jmp_flag) begin
                    pc_d    = addr_field;
                    state_d = S_ISSUE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (bus.instr_ready) state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // adp_bus/rd are registered off the next state so rd is high exactly in ISSUE
    // and the address is held afterwards.
    always_ff @(posedge clk_pgm) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            adp_q      <= RESET_PC;
            rd_q       <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rd_q    <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) adp_q <= pc_d;
            if (load_instr) begin
                instr_q    <= bus.pgm_line;
                instr_pc_q <= pc_q;
            end
        end
    end

    assign bus.adp_bus     = adp_q;
    assign bus.rd          = rd_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.halted      = (state_q == S_IDLE) || (state_q == S_HALT);
endmodule
